zxw_sw_conditioner: RTL and testbench
=====================================

Name: zxw_sw_conditioner

Overview:
Upstream input stage for zxw_lab9. Takes the five raw slide-switch inputs, synchronises and debounces each bit, and presents each new stable switch word to the lab9 core over a four-phase Req/Ack handshake. Its outputs replace the direct SW_in drive of the core.

Parameters:
NUM_SW, 5, number of switch bits; must match the core's SW_in width.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a bit flips; legal range 2..65535.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.
TIMEOUT_CYCLES, 64, Req-without-Ack limit; used only with the optional feature.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
SW_raw  input  NUM_SW  raw switch pins; asynchronous to Clock.
Ack  input  1  core acknowledge for the four-phase handshake.
SW_out  output  NUM_SW  debounced word presented to the core; stable whenever Req=1.
Req  output  1  transaction request.
Changed  output  NUM_SW  bit mask of SW_out bits that differ from the previously delivered word; valid with Req.
Timeout_err  output  1  sticky error flag; present only when ZXW_SW_TIMEOUT_EN is defined.

Behaviour:
- Reset (async, active-high): sync flops, debounced vector SW_deb, counters, SW_out, Changed and Req all go to 0. State goes to IDLE. Req drops in the same instant Reset asserts, including mid-transaction.
- Sync: 2-flop synchroniser per bit. The first flop's output is never used by other logic.
- Debounce, per bit, independent:
  - Synced bit equal to SW_deb bit -> counter cleared.
  - Synced bit differs -> counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 while the bit still differs -> SW_deb bit flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves SW_deb unchanged.
- Latency: a raw change held steady appears on SW_deb DEBOUNCE_CYCLES+2 cycles later. Req rises 1 cycle after that.
- Handshake FSM, states IDLE, REQ, HOLD:
  - IDLE: Req=0. If SW_deb != SW_out, register SW_out<=SW_deb and Changed<=SW_deb^SW_out, then go to REQ. Ack is ignored in IDLE.
  - REQ: Req=1. SW_out and Changed are frozen. Ack=1 -> HOLD.
  - HOLD: Req=0. SW_out is still held. Ack=0 -> IDLE.
- Boundary conditions:
  - Debounce continues during REQ/HOLD; SW_deb keeps updating.
  - Only the net difference is delivered on return to IDLE. A bit that toggles and returns during a transaction generates no new transaction.
  - Multiple bits settling in the same cycle produce one transaction with a multi-bit Changed mask.
  - Switches high at reset release generate one transaction after debounce, because SW_out resets to 0.
  - Ack held high continuously after HOLD: the FSM stays in HOLD, so no back-to-back Req is issued without an Ack release.
- Width rules: counters saturate by construction and never wrap. Changed is pure XOR, with no arithmetic.

Optional Feature:
Macro ZXW_SW_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ.
  - If it reaches TIMEOUT_CYCLES with Ack still 0, Req drops, the FSM returns to IDLE, and Timeout_err sets.
  - SW_out is retained, so the pending word is re-offered on the next IDLE cycle only if SW_deb differs.
  - Timeout_err clears only on Reset.
- Not defined: no timeout counter and no Timeout_err port; REQ waits indefinitely for Ack.

Decomposition:
- Package zxw_sw_pkg:
  - state enum {IDLE, REQ, HOLD}, 2-bit encoding 00/01/10
  - localparam NUM_SW_DEFAULT=5
  - a clog2 helper function
- Sub-module zxw_debounce_bit: synchroniser plus counter for one bit, parameterised by DEBOUNCE_CYCLES. Instantiated NUM_SW times with a generate loop.
- FSM and output registers live in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset hold: Reset=1 for 10 cycles, SW_raw=5'b10101 -> SW_out=0, Req=0, Changed=0 throughout.
2. Clean press: SW_raw 00000->00100 held -> Req rises exactly 7 cycles after the change; SW_out=00100, Changed=00100. Ack raised 2 cycles later -> Req falls next cycle. Ack dropped -> IDLE, no further Req.
3. Glitch reject: SW_raw bit0 pulses high for 2 cycles -> no Req, SW_out unchanged.
4. Change during transaction: hold Req unacked, change SW_raw 00100->00110 and settle. After Ack high then low -> a second Req with SW_out=00110, Changed=00010. A bit toggled and restored inside REQ -> no extra Req.
5. Simultaneous bits plus async reset: SW_raw 00000->11111 -> one Req with Changed=11111. Assert Reset while Req=1 -> Req=0 immediately, not on the next edge.
6. With ZXW_SW_TIMEOUT_EN and TIMEOUT_CYCLES=8: Req with Ack tied 0 -> Req drops after 8 cycles and Timeout_err=1, which stays set until Reset.

Source files
------------

// File: rtl/zxw_sw_conditioner_pkg.sv
// Shared types and helpers for the zxw_lab9 switch conditioner.
// The handshake state encoding is fixed at 00/01/10.
package zxw_sw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam int NUM_SW_DEFAULT = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/zxw_sw_conditioner_if.sv
// Four-phase Req/Ack bus between the switch conditioner (master) and the lab9 core (slave).
interface zxw_sw_conditioner_if
  import zxw_sw_pkg::*;
#(
  parameter int NUM_SW = NUM_SW_DEFAULT
);

  logic [NUM_SW-1:0] SW_out;
  logic              Req;
  logic [NUM_SW-1:0] Changed;
  logic              Ack;

  modport master (output SW_out, output Req, output Changed, input Ack);
  modport slave  (input SW_out, input Req, input Changed, output Ack);

endinterface

// File: rtl/zxw_sw_conditioner_debounce.sv
// One switch bit: two-flop synchroniser followed by a run-length debounce counter.
module zxw_debounce_bit
  import zxw_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // synchroniser chain; sync1_q feeds nothing but sync2_q
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // count consecutive disagreeing cycles; the counter never passes CNT_LAST
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // debounce state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/zxw_sw_conditioner.sv
// Debounces the raw switches and offers each new stable word to the lab9 core over Req/Ack.
// Optional Req timeout and sticky Timeout_err are enabled by defining ZXW_SW_TIMEOUT_EN.
module zxw_sw_conditioner
  import zxw_sw_pkg::*;
#(
  parameter int NUM_SW          = NUM_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_SW-1:0]    SW_raw,
  zxw_sw_conditioner_if.master bus
`ifdef ZXW_SW_TIMEOUT_EN
  ,
  output logic                 Timeout_err
`endif
);

  state_e            state_q;
  state_e            state_d;
  logic [NUM_SW-1:0] sw_deb_s;
  logic [NUM_SW-1:0] sw_out_q;
  logic [NUM_SW-1:0] sw_out_d;
  logic [NUM_SW-1:0] changed_q;
  logic [NUM_SW-1:0] changed_d;
  logic              req_q;
  logic              req_d;
  logic              timeout_s;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    zxw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i (Clock),
      .rst_i (Reset),
      .raw_i (SW_raw[i]),
      .deb_o (sw_deb_s[i])
    );
  end

`ifdef ZXW_SW_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            err_q;
  logic            err_d;

  assign timeout_s = (state_q == REQ) && !bus.Ack && (to_cnt_q == TO_LAST);

  // count cycles spent waiting in REQ; cleared on any exit, so it cannot wrap
  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q | timeout_s;
    if ((state_q == REQ) && (state_d == REQ)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = '0;
    end
  end

  // timeout counter and sticky error flag, cleared only by Reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign Timeout_err = err_q;
`else
  assign timeout_s = 1'b0;
`endif

  // handshake state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // handshake next-state logic; Ack is ignored in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sw_deb_s != sw_out_q) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.Ack) begin
          state_d = HOLD;
        end else if (timeout_s) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (!bus.Ack) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // capture the word only when launching a transaction; frozen through REQ and HOLD
  always_comb begin
    sw_out_d  = sw_out_q;
    changed_d = changed_q;
    req_d     = (state_d == REQ);
    if ((state_q == IDLE) && (state_d == REQ)) begin
      sw_out_d  = sw_deb_s;
      changed_d = sw_deb_s ^ sw_out_q;
    end else begin
      sw_out_d  = sw_out_q;
      changed_d = changed_q;
    end
  end

  // output registers; async reset drops Req the instant Reset rises
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_out_q  <= '0;
      changed_q <= '0;
      req_q     <= 1'b0;
    end else begin
      sw_out_q  <= sw_out_d;
      changed_q <= changed_d;
      req_q     <= req_d;
    end
  end

  assign bus.SW_out  = sw_out_q;
  assign bus.Changed = changed_q;
  assign bus.Req     = req_q;

endmodule

// File: tb/tb_zxw_sw_conditioner.sv
// Directed self-checking bench for zxw_sw_conditioner (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8).
module tb_zxw_sw_conditioner;

  logic       Clock;
  logic       Reset;
  logic [4:0] SW_raw;
  int         errors;
  int         checks;
`ifdef ZXW_SW_TIMEOUT_EN
  logic       Timeout_err;
`endif

  zxw_sw_conditioner_if #(.NUM_SW(5)) bus_if ();

  zxw_sw_conditioner #(
    .NUM_SW          (5),
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .SW_raw (SW_raw),
    .bus    (bus_if)
`ifdef ZXW_SW_TIMEOUT_EN
    ,
    .Timeout_err (Timeout_err)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input string tag, input logic [4:0] word, input logic [4:0] mask);
    chk({tag, "_req"}, {7'd0, bus_if.Req}, 8'd1);
    chk({tag, "_out"}, {3'd0, bus_if.SW_out}, {3'd0, word});
    chk({tag, "_chg"}, {3'd0, bus_if.Changed}, {3'd0, mask});
  endtask

  task automatic handshake(input string tag);
    bus_if.Ack = 1'b1;
    tick(1);
    chk({tag, "_hold_req"}, {7'd0, bus_if.Req}, 8'd0);
    bus_if.Ack = 1'b0;
    tick(2);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    Clock       = 1'b0;
    Reset       = 1'b1;
    SW_raw      = 5'b10101;
    bus_if.Ack  = 1'b0;

    // 1. reset hold
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("rst_out", {3'd0, bus_if.SW_out}, 8'd0);
      chk("rst_req", {7'd0, bus_if.Req}, 8'd0);
      chk("rst_chg", {3'd0, bus_if.Changed}, 8'd0);
    end
    SW_raw = 5'b00000;
    Reset  = 1'b0;
    tick(10);
    chk("idle_req", {7'd0, bus_if.Req}, 8'd0);

    // 2. clean press: Req exactly 7 cycles after the change
    SW_raw = 5'b00100;
    tick(6);
    chk("press_early", {7'd0, bus_if.Req}, 8'd0);
    tick(1);
    expect_req("press", 5'b00100, 5'b00100);
    tick(2);
    chk("press_wait", {7'd0, bus_if.Req}, 8'd1);
    handshake("press");
    tick(8);
    chk("press_after", {7'd0, bus_if.Req}, 8'd0);

    // 3. 2-cycle glitch is rejected
    SW_raw = 5'b00101;
    tick(2);
    SW_raw = 5'b00100;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch_req", {7'd0, bus_if.Req}, 8'd0);
    end
    chk("glitch_out", {3'd0, bus_if.SW_out}, 8'h04);

    // 4. changes during a transaction
    SW_raw = 5'b00110;
    tick(7);
    expect_req("chg1", 5'b00110, 5'b00010);
    SW_raw = 5'b01110;
    tick(8);
    SW_raw = 5'b00110;
    tick(12);
    expect_req("toggle_frozen", 5'b00110, 5'b00010);
    handshake("chg1");
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("toggle_noreq", {7'd0, bus_if.Req}, 8'd0);
    end
    SW_raw = 5'b00111;
    tick(7);
    expect_req("chg2", 5'b00111, 5'b00001);
    bus_if.Ack = 1'b1;
    tick(1);
    SW_raw = 5'b00011;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("ackhigh_noreq", {7'd0, bus_if.Req}, 8'd0);
    end
    bus_if.Ack = 1'b0;
    tick(2);
    expect_req("chg3", 5'b00011, 5'b00100);
    handshake("chg3");

    // 5. simultaneous bits, then async reset mid-transaction
    SW_raw = 5'b00000;
    tick(7);
    expect_req("clr", 5'b00000, 5'b00011);
    handshake("clr");
    SW_raw = 5'b11111;
    tick(6);
    chk("multi_early", {7'd0, bus_if.Req}, 8'd0);
    tick(1);
    expect_req("multi", 5'b11111, 5'b11111);
    Reset = 1'b1;
    #1;
    chk("async_req", {7'd0, bus_if.Req}, 8'd0);
    chk("async_out", {3'd0, bus_if.SW_out}, 8'd0);
    chk("async_chg", {3'd0, bus_if.Changed}, 8'd0);
    tick(3);
    Reset = 1'b0;
    tick(6);
    chk("relhi_early", {7'd0, bus_if.Req}, 8'd0);
    tick(1);
    expect_req("relhi", 5'b11111, 5'b11111);
    handshake("relhi");

`ifdef ZXW_SW_TIMEOUT_EN
    // 6. Req timeout with Ack tied low
    chk("to_init", {7'd0, Timeout_err}, 8'd0);
    SW_raw = 5'b00000;
    tick(7);
    expect_req("to", 5'b00000, 5'b11111);
    tick(7);
    chk("to_still_req", {7'd0, bus_if.Req}, 8'd1);
    chk("to_no_err", {7'd0, Timeout_err}, 8'd0);
    tick(1);
    chk("to_drop", {7'd0, bus_if.Req}, 8'd0);
    chk("to_err", {7'd0, Timeout_err}, 8'd1);
    tick(10);
    chk("to_sticky", {7'd0, Timeout_err}, 8'd1);
    chk("to_noreoffer", {7'd0, bus_if.Req}, 8'd0);
    Reset = 1'b1;
    tick(1);
    chk("to_clear", {7'd0, Timeout_err}, 8'd0);
    Reset = 1'b0;
    tick(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
